// File: rtl/emergency_arbiter_if.sv
// rtl/emergency_arbiter_if.sv - handshake/bus bundle for the emergency-vehicle arbiter
//
// Purpose: groups the tick timebase, raw sensor requests and the arbiter's
// registered outputs so the arbiter and its environment share one port.
// Signals:
//   tick            - one-cycle timebase enable (1 s)
//   req[3:0]        - raw emergency-vehicle sensor requests (0-1 right, 2-3 left)
//   grant[3:0]      - registered one-hot grant, 0 when nothing is granted
//   emergency_right - registered grant[0]|grant[1]
//   emergency_left  - registered grant[2]|grant[3]
//   pending[3:0]    - latched accepted requests awaiting or holding service
//   busy            - high while granting or in the all-quiet interval
// Modports: master drives tick/req (environment), slave is the arbiter.

interface emergency_arbiter_if;
  logic       tick;
  logic [3:0] req;
  logic [3:0] grant;
  logic       emergency_right;
  logic       emergency_left;
  logic [3:0] pending;
  logic       busy;

  modport master (
    output tick,
    output req,
    input  grant,
    input  emergency_right,
    input  emergency_left,
    input  pending,
    input  busy
  );

  modport slave (
    input  tick,
    input  req,
    output grant,
    output emergency_right,
    output emergency_left,
    output pending,
    output busy
  );
endinterface

// File: rtl/emergency_arbiter.sv
// rtl/emergency_arbiter.sv - debounced emergency-vehicle request arbiter with hold, extension and clear interval
//
// Purpose: debounces four raw emergency sensor requests, latches accepted ones
// in pending, and grants one approach at a time. The right group (bits 0-1)
// has strict priority over the left group (bits 2-3). A grant lasts
// HOLD_TICKS ticks and may be extended up to MAX_EXT times while its request
// is still raised; every grant is followed by CLEAR_TICKS all-quiet ticks.
// All timing advances only on clk edges with tick=1.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - emergency_arbiter_if.slave (tick, req in; grant, emergency_right,
//           emergency_left, pending, busy out)
// Configuration macro: EMERG_ARB_ROUND_ROBIN_EN
//   defined   - round-robin choice inside each group (one pointer per group)
//   undefined - lowest pending index inside each group

module emergency_arbiter #(
  parameter int HOLD_TICKS  = 10,
  parameter int MAX_EXT     = 2,
  parameter int CLEAR_TICKS = 3,
  parameter int DEB_TICKS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  emergency_arbiter_if.slave  bus
);

  localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int EW = (MAX_EXT     > 0) ? $clog2(MAX_EXT + 1) : 1;
  localparam int CW = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
  localparam logic [EW-1:0] EXT_LIMIT  = EW'(MAX_EXT);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_TICKS - 1);
  localparam logic [DW-1:0] DEB_FULL   = DW'(DEB_TICKS);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    qual;
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [EW-1:0] ext_cnt;
  logic [CW-1:0] clr_cnt;
  logic [1:0]    gsel;
  logic [1:0]    sel;
  logic [3:0]    pending_q;
  logic [3:0]    grant_q;
  logic          em_right_q;
  logic          em_left_q;
  logic          start_grant;
  logic          can_extend;
  logic          release_grant;
  logic [3:0]    clr_mask;

  // Debounce: count ticks while high, drop to zero on any edge while low.
  // The count saturates at DEB_TICKS so a request held high keeps
  // re-qualifying on every tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[i]) begin
          deb_cnt[i] <= '0;
        end else if (bus.tick && (deb_cnt[i] != DEB_FULL)) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A bit qualifies on the tick edge whose count reaches (or stays at) DEB_TICKS.
  always_comb begin
    qual = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      qual[i] = bus.tick && bus.req[i] && (deb_cnt[i] >= DEB_LAST);
    end
  end

  assign start_grant   = bus.tick && (state == ST_IDLE) && (pending_q != 4'b0000);
  assign can_extend    = bus.req[gsel] && (ext_cnt < EXT_LIMIT);
  assign release_grant = bus.tick && (state == ST_GRANT) && (hold_cnt == '0) && !can_extend;
  // Clearing the served bit wins over a same-edge re-qualification; a request
  // still held re-latches on the following tick.
  assign clr_mask      = release_grant ? (4'b0001 << gsel) : 4'b0000;

`ifdef EMERG_ARB_ROUND_ROBIN_EN
  // Each pointer names the preferred bit inside its group: the bit after the
  // one granted last. Reset prefers bit 0 (right) and bit 2 (left).
  logic rr_right;
  logic rr_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_right <= 1'b0;
      rr_left  <= 1'b0;
    end else if (start_grant) begin
      if (sel[1]) rr_left  <= ~sel[0];
      else        rr_right <= ~sel[0];
    end
  end

  always_comb begin
    sel = 2'd0;
    if (pending_q[1:0] != 2'b00) begin
      sel = pending_q[{1'b0, rr_right}] ? {1'b0, rr_right} : {1'b0, ~rr_right};
    end else begin
      sel = pending_q[{1'b1, rr_left}] ? {1'b1, rr_left} : {1'b1, ~rr_left};
    end
  end
`else
  always_comb begin
    sel = 2'd3;
    if (pending_q[0])      sel = 2'd0;
    else if (pending_q[1]) sel = 2'd1;
    else if (pending_q[2]) sel = 2'd2;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      ext_cnt    <= '0;
      clr_cnt    <= '0;
      gsel       <= 2'd0;
      grant_q    <= 4'b0000;
      em_right_q <= 1'b0;
      em_left_q  <= 1'b0;
      pending_q  <= 4'b0000;
    end else begin
      pending_q <= (pending_q | qual) & ~clr_mask;
      if (bus.tick) begin
        case (state)
          ST_IDLE: begin
            if (start_grant) begin
              state      <= ST_GRANT;
              hold_cnt   <= HOLD_LOAD;
              ext_cnt    <= '0;
              gsel       <= sel;
              grant_q    <= 4'b0001 << sel;
              em_right_q <= ~sel[1];
              em_left_q  <= sel[1];
            end
          end
          ST_GRANT: begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - 1'b1;
            end else if (can_extend) begin
              hold_cnt <= HOLD_LOAD;
              ext_cnt  <= ext_cnt + 1'b1;
            end else begin
              state      <= ST_CLEAR;
              clr_cnt    <= CLEAR_LOAD;
              grant_q    <= 4'b0000;
              em_right_q <= 1'b0;
              em_left_q  <= 1'b0;
            end
          end
          ST_CLEAR: begin
            if (clr_cnt == '0) state   <= ST_IDLE;
            else               clr_cnt <= clr_cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.grant           = grant_q;
  assign bus.emergency_right = em_right_q;
  assign bus.emergency_left  = em_left_q;
  assign bus.pending         = pending_q;
  assign bus.busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_emergency_arbiter.sv
// tb/tb_emergency_arbiter.sv - self-checking bench for emergency_arbiter

module tb_emergency_arbiter;
  localparam int HOLD = 10;
  localparam int MAXE = 2;
  localparam int CLR  = 3;
  localparam int DEB  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  emergency_arbiter_if bus_if();

  emergency_arbiter #(
    .HOLD_TICKS (HOLD),
    .MAX_EXT    (MAXE),
    .CLEAR_TICKS(CLR),
    .DEB_TICKS  (DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: consecutive-tick debounce, elapsed-tick grant timing.
  int         m_deb [4];
  logic [3:0] m_pend;
  int         m_owner;   // granted index, -1 when nothing granted
  bit         m_clear;
  int         m_el;      // ticks since grant start
  int         m_ext;
  int         m_q;       // ticks spent in the quiet interval
`ifdef EMERG_ARB_ROUND_ROBIN_EN
  int         m_last [2]; // last granted bit within each group
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_deb[i] = 0;
    m_pend  = 4'b0000;
    m_owner = -1;
    m_clear = 1'b0;
    m_el    = 0;
    m_ext   = 0;
    m_q     = 0;
`ifdef EMERG_ARB_ROUND_ROBIN_EN
    m_last[0] = 1;
    m_last[1] = 1;
`endif
  endtask

  function automatic int pick(input logic [3:0] p);
    for (int g = 0; g < 2; g++) begin
      int first;
      if (p[2*g] || p[2*g+1]) begin
`ifdef EMERG_ARB_ROUND_ROBIN_EN
        first = 2*g + ((m_last[g] + 1) % 2);
`else
        first = 2*g;
`endif
        return p[first] ? first : (first ^ 1);
      end
    end
    return -1;
  endfunction

  task automatic model_edge(input bit t, input logic [3:0] r);
    logic [3:0] set_m;
    logic [3:0] clr_m;
    set_m = 4'b0000;
    clr_m = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) m_deb[i] = 0;
      else if (t) begin
        m_deb[i]++;
        if (m_deb[i] >= DEB) set_m[i] = 1'b1;
      end
    end
    if (t) begin
      if (m_owner >= 0) begin
        m_el++;
        if (m_el == HOLD * (1 + m_ext)) begin
          if (r[m_owner] && m_ext < MAXE) m_ext++;
          else begin
            clr_m[m_owner] = 1'b1;
            m_owner = -1;
            m_clear = 1'b1;
            m_q = 0;
          end
        end
      end else if (m_clear) begin
        m_q++;
        if (m_q == CLR) m_clear = 1'b0;
      end else if (m_pend != 4'b0000) begin
        m_owner = pick(m_pend);
        m_el = 0;
        m_ext = 0;
`ifdef EMERG_ARB_ROUND_ROBIN_EN
        m_last[m_owner / 2] = m_owner % 2;
`endif
      end
    end
    m_pend = (m_pend | set_m) & ~clr_m;
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check({tag, "_grant"},   bus_if.grant, eg);
    check({tag, "_right"},   bus_if.emergency_right, (m_owner == 0 || m_owner == 1));
    check({tag, "_left"},    bus_if.emergency_left,  (m_owner == 2 || m_owner == 3));
    check({tag, "_pending"}, bus_if.pending, m_pend);
    check({tag, "_busy"},    bus_if.busy, (m_owner >= 0 || m_clear));
  endtask

  // Drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input bit t, input logic [3:0] r);
    bus_if.tick = t;
    bus_if.req  = r;
    @(posedge clk);
    model_edge(t, r);
    @(negedge clk);
    compare_all("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.tick = 1'b0;
    bus_if.req  = 4'b0000;
    @(negedge clk);
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_g;
    int cnt_q;
    int run;
    bit in_first;
    bit seen;
    logic [3:0] prev;
    logic [3:0] rq;
    logic [3:0] rises [$];

    bus_if.tick = 1'b0;
    bus_if.req  = 4'b0000;
    model_reset();

    // Single right request: debounce, 10-tick grant, 3 quiet ticks.
    do_reset();
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    check("a_pending", bus_if.pending, 4'b0001);
    check("a_no_grant_yet", bus_if.grant, 4'b0000);
    step(1'b1, 4'b0000);
    check("a_grant", bus_if.grant, 4'b0001);
    check("a_em_right", bus_if.emergency_right, 1'b1);
    cnt_g = 1;
    cnt_q = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 4'b0000);
      if (bus_if.grant == 4'b0001) cnt_g++;
      else if (bus_if.busy && !bus_if.emergency_right && !bus_if.emergency_left) cnt_q++;
    end
    check("a_hold_len", cnt_g, 10);
    check("a_quiet_len", cnt_q, 3);
    check("a_idle", bus_if.busy, 1'b0);

    // Right beats left when both qualify on the same tick.
    do_reset();
    step(1'b1, 4'b0110);
    step(1'b1, 4'b0110);
    rises.delete();
    prev = bus_if.grant;
    for (int c = 0; c < 60; c++) begin
      step(1'b1, 4'b0000);
      if (bus_if.grant != 4'b0000 && prev == 4'b0000) rises.push_back(bus_if.grant);
      prev = bus_if.grant;
    end
    check("b_num_grants", rises.size(), 2);
    if (rises.size() >= 2) begin
      check("b_first", rises[0], 4'b0010);
      check("b_second", rises[1], 4'b0100);
    end

    // Held request: two extensions (30 ticks), quiet, then re-grant of bit 0.
    do_reset();
    rises.delete();
    prev = 4'b0000;
    run = 0;
    in_first = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step(1'b1, 4'b0001);
      if (bus_if.grant != 4'b0000 && prev == 4'b0000) rises.push_back(bus_if.grant);
      if (in_first && bus_if.grant == 4'b0001) run++;
      if (run > 0 && bus_if.grant == 4'b0000) in_first = 1'b0;
      prev = bus_if.grant;
    end
    check("c_hold_len", run, 30);
    check("c_regranted", (rises.size() >= 2), 1'b1);
    if (rises.size() >= 2) check("c_regrant_bit", rises[1], 4'b0001);

    // One-tick glitch never qualifies.
    do_reset();
    step(1'b1, 4'b0010);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(1'b1, 4'b0000);
      if (bus_if.grant != 4'b0000) seen = 1'b1;
    end
    check("d_pending", bus_if.pending, 4'b0000);
    check("d_no_grant", seen, 1'b0);

    // Both right bits held: alternate with round robin, else bit 0 repeatedly.
    do_reset();
    rises.delete();
    prev = 4'b0000;
    for (int c = 0; c < 150; c++) begin
      step(1'b1, 4'b0011);
      if (bus_if.grant != 4'b0000 && prev == 4'b0000) rises.push_back(bus_if.grant);
      prev = bus_if.grant;
    end
    check("e_num_grants", (rises.size() >= 3), 1'b1);
    if (rises.size() >= 3) begin
      check("e_g0", rises[0], 4'b0001);
`ifdef EMERG_ARB_ROUND_ROBIN_EN
      check("e_g1", rises[1], 4'b0010);
`else
      check("e_g1", rises[1], 4'b0001);
`endif
      check("e_g2", rises[2], 4'b0001);
    end

    // Left grant is not preempted by a right request; tick=0 freezes; async reset.
    do_reset();
    step(1'b1, 4'b0100);
    step(1'b1, 4'b0100);
    step(1'b1, 4'b0000);
    check("f_left_grant", bus_if.grant, 4'b0100);
    check("f_em_left", bus_if.emergency_left, 1'b1);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    check("f_no_preempt", bus_if.grant, 4'b0100);
    check("f_pending_both", bus_if.pending, 4'b0101);
    for (int c = 0; c < 20; c++) step(1'b0, 4'b0001);
    check("f_frozen_grant", bus_if.grant, 4'b0100);
    #2;
    reset = 1'b1;
    #1;
    check("f_async_grant", bus_if.grant, 4'b0000);
    check("f_async_right", bus_if.emergency_right, 1'b0);
    check("f_async_left", bus_if.emergency_left, 1'b0);
    check("f_async_pending", bus_if.pending, 4'b0000);
    check("f_async_busy", bus_if.busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with sticky request levels and sparse ticks.
    rq = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      step($urandom_range(0, 3) != 0, rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/emergency_arbiter.md
EMERGENCY_ARBITER -- requirements
Module: emergency_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 10, meaning minimum grant duration in ticks.
REQ-002 SHALL have parameter MAX_EXT, default 2, meaning maximum number of hold extensions per grant.
REQ-003 SHALL have parameter CLEAR_TICKS, default 3, meaning all-quiet interval after each grant in ticks.
REQ-004 SHALL have parameter DEB_TICKS, default 2, meaning consecutive high ticks needed to accept a request.
REQ-005 SHALL have port clk, input, 1, meaning system clock.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port tick, input, 1, meaning one-cycle timebase enable (1 s); all timing SHALL advance only on clk edges with tick=1.
REQ-008 SHALL have port req, input, 4, meaning raw emergency-vehicle sensor requests; bits 0-1 are right approaches, bits 2-3 are left approaches.
REQ-009 SHALL have port grant, output, 4, meaning registered one-hot grant; 0 when no grant.
REQ-010 SHALL have port emergency_right, output, 1, meaning registered drive to the light controller's Emergency_Right, equal to grant[0]|grant[1].
REQ-011 SHALL have port emergency_left, output, 1, meaning registered drive to the light controller's Emergency_Left, equal to grant[2]|grant[3].
REQ-012 SHALL have port pending, output, 4, meaning latched accepted requests awaiting or holding service.
REQ-013 SHALL have port busy, output, 1, meaning high in the GRANT and CLEAR states.

Function
REQ-014 SHALL debounce each req bit with a per-bit counter: increment on tick while high, clear on any clk edge while low; set pending[i] when the count reaches DEB_TICKS.
REQ-015 SHALL implement states IDLE, GRANT and CLEAR.
REQ-016 In IDLE on tick with pending!=0, SHALL enter GRANT, load the hold counter with HOLD_TICKS-1 and the extension counter with 0, and assert exactly one grant bit on the same edge.
REQ-017 Selection SHALL give the right group (bits 0-1) strict priority over the left group (bits 2-3); the choice within a group is set by REQ-028/029.
REQ-018 In GRANT on tick, SHALL decrement the hold counter while it is non-zero.
REQ-019 When the hold counter is 0 on tick and req[g] is still high and the extension count is below MAX_EXT, SHALL reload HOLD_TICKS-1 and increment the extension count.
REQ-020 When the hold counter is 0 on tick otherwise, SHALL clear pending[g] and grant, enter CLEAR and load CLEAR_TICKS-1.
REQ-021 Each grant SHALL therefore last HOLD_TICKS*(1+E) ticks, where E<=MAX_EXT (default maximum 30 ticks).
REQ-022 In CLEAR, grant, emergency_right and emergency_left SHALL be 0; on tick with the counter at 0 SHALL enter IDLE, otherwise decrement.
REQ-023 Requests accepted during GRANT or CLEAR SHALL remain in pending and SHALL never preempt the active grant, including a right request during a left grant.
REQ-024 If req[g] re-qualifies while g is granted, pending[g] SHALL stay set, and pending[g] SHALL be cleared only at REQ-020.
REQ-025 tick=0 SHALL freeze all counters and state except the debounce clear of REQ-014.

Reset
REQ-026 Asynchronous reset SHALL force IDLE, grant=0, emergency_right=0, emergency_left=0, pending=0, busy=0, all counters 0 and round-robin pointers to bit 0/2, including mid-grant.
REQ-027 On the first tick after reset release with qualified requests, SHALL behave as in REQ-016.

Configuration
REQ-028 With EMERG_ARB_ROUND_ROBIN_EN defined, SHALL pick within a group the pending bit after the last granted bit of that group (pointer per group, updated at grant).
REQ-029 Without EMERG_ARB_ROUND_ROBIN_EN, SHALL pick the lowest pending index within the group, with no pointer logic.

Verification
REQ-030 req=0001 held 2 ticks -> pending=0001; next tick grant=0001, emergency_right=1; released after 10 ticks; 3 ticks with both outputs 0; then IDLE.
REQ-031 req=0100 and req=0010 qualifying on the same tick -> grant=0010 first, then grant=0100 after that grant and CLEAR complete.
REQ-032 req[0] held high continuously -> grant lasts exactly 30 ticks (2 extensions), then CLEAR, then re-grant of bit 0.
REQ-033 req[1] 1-tick glitch -> pending stays 0 and no grant.
REQ-034 With round robin enabled, req=0011 held -> grants alternate 0001, 0010, 0001; without it, 0001 is granted repeatedly.
REQ-035 reset asserted mid-GRANT -> grant=0, emergency outputs=0 and pending=0 asynchronously, before the next clk edge.
